// File: rtl/synth_pkg.sv
// Shared definitions for the voice allocation slice.
// Provides the allocator FSM state encoding, the default note width and
// a constant-evaluable ceiling-log2 helper used to size voice indices
// and small counters.
package synth_pkg;

  // Allocator FSM states; encoding is fixed so debug probes stay stable.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    GAP    = 2'd2,
    ASSIGN = 2'd3
  } state_t;

  // MIDI note numbers are 7 bits wide.
  localparam int DEFAULT_NOTE_BITS = 7;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/voice_picker.sv
// Combinational target-voice selector for a note-on event.
// Ports:
//   gate       in  NUM_VOICES             current per-voice gate
//   voice_idle in  NUM_VOICES             envelope finished (amplitude 0)
//   ages       in  NUM_VOICES*AGE_BITS    per-voice LRU age, voice i at [i*AGE_BITS +: AGE_BITS]
//   notes      in  NUM_VOICES*NOTE_BITS   per-voice note, voice i at [i*NOTE_BITS +: NOTE_BITS]
//   ev_note    in  NOTE_BITS              note requested by the event
//   target     out clog2(NUM_VOICES)      chosen voice index
//   needs_gap  out 1                      chosen voice is currently gated and
//                                         must see a gate-low gap before re-gating
// Priority: gated voice already on this note, then lowest-index idle
// voice, then oldest releasing voice, then oldest gated voice.
// "Oldest" is the largest age with ties resolved to the lowest index.
module voice_picker
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_BITS  = DEFAULT_NOTE_BITS,
  parameter int AGE_BITS   = 4
) (
  input  logic [NUM_VOICES-1:0]           gate,
  input  logic [NUM_VOICES-1:0]           voice_idle,
  input  logic [NUM_VOICES*AGE_BITS-1:0]  ages,
  input  logic [NUM_VOICES*NOTE_BITS-1:0] notes,
  input  logic [NOTE_BITS-1:0]            ev_note,
  output logic [clog2(NUM_VOICES)-1:0]    target,
  output logic                            needs_gap
);

  localparam int IDX_W = clog2(NUM_VOICES);

  logic             found_match, found_free, found_rel, found_gated;
  logic [IDX_W-1:0] match_idx, free_idx, rel_idx, gated_idx;
  logic [AGE_BITS-1:0] rel_age, gated_age, age_i;
  logic [NOTE_BITS-1:0] note_i;

  // One ascending scan builds all four candidates. Using a strict '>' on
  // age means an equal age seen later never displaces an earlier index,
  // which gives the lowest-index tie-break for free.
  always_comb begin
    found_match = 1'b0;
    found_free  = 1'b0;
    found_rel   = 1'b0;
    found_gated = 1'b0;
    match_idx   = '0;
    free_idx    = '0;
    rel_idx     = '0;
    gated_idx   = '0;
    rel_age     = '0;
    gated_age   = '0;
    age_i       = '0;
    note_i      = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      age_i  = ages[i*AGE_BITS +: AGE_BITS];
      note_i = notes[i*NOTE_BITS +: NOTE_BITS];
      if (gate[i]) begin
        if (!found_match && note_i == ev_note) begin
          found_match = 1'b1;
          match_idx   = IDX_W'(i);
        end
        if (!found_gated || age_i > gated_age) begin
          found_gated = 1'b1;
          gated_age   = age_i;
          gated_idx   = IDX_W'(i);
        end
      end else begin
        if (!found_free && voice_idle[i]) begin
          found_free = 1'b1;
          free_idx   = IDX_W'(i);
        end
        if (!found_rel || age_i > rel_age) begin
          found_rel = 1'b1;
          rel_age   = age_i;
          rel_idx   = IDX_W'(i);
        end
      end
    end
  end

  // Final priority mux; the steal case is the fallback because when no
  // ungated voice exists every voice is gated.
  always_comb begin
    target    = gated_idx;
    needs_gap = 1'b1;
    if (found_match) begin
      target    = match_idx;
      needs_gap = 1'b1;
    end else if (found_free) begin
      target    = free_idx;
      needs_gap = 1'b0;
    end else if (found_rel) begin
      target    = rel_idx;
      needs_gap = 1'b0;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony controller driving a bank of envelope generators.
// Ports:
//   clk        in  1                      system clock (shared with envelopes)
//   rst        in  1                      synchronous active-high reset
//   ev_valid   in  1                      event present
//   ev_ready   out 1                      event accepted on ev_valid && ev_ready
//   ev_on      in  1                      1 = note-on, 0 = note-off
//   ev_note    in  NOTE_BITS              event note number
//   voice_idle in  NUM_VOICES             per-voice envelope-finished flag
//   gate       out NUM_VOICES             per-voice gate
//   voice_note out NUM_VOICES*NOTE_BITS   per-voice note, voice i at [i*NOTE_BITS +: NOTE_BITS]
//   busy       out 1                      FSM not in IDLE
// One event is processed at a time: IDLE accepts, SEARCH decides, and
// retriggers/steals pass through GAP so the envelope sees a gate-low gap
// of exactly RETRIG_CYCLES cycles before re-gating.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES    = 4,
  parameter int NOTE_BITS     = DEFAULT_NOTE_BITS,
  parameter int AGE_BITS      = 4,
  parameter int RETRIG_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_on,
  input  logic [NOTE_BITS-1:0]            ev_note,
  input  logic [NUM_VOICES-1:0]           voice_idle,
  output logic [NUM_VOICES-1:0]           gate,
  output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
  output logic                            busy
);

  localparam int IDX_W = clog2(NUM_VOICES);
  localparam int GAP_W = clog2(RETRIG_CYCLES + 1);
  localparam logic [AGE_BITS-1:0] AGE_MAX = {AGE_BITS{1'b1}};

  state_t                         state, state_next;
  logic                           ev_on_r;
  logic [NOTE_BITS-1:0]           ev_note_r;
  logic [IDX_W-1:0]               target_r;
  logic [GAP_W-1:0]               gap_cnt;
  logic [NUM_VOICES*AGE_BITS-1:0] ages, ages_next;
  logic [IDX_W-1:0]               pick;
  logic                           pick_gap;
  logic [IDX_W-1:0]               assign_idx;

  assign ev_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  voice_picker #(
    .NUM_VOICES (NUM_VOICES),
    .NOTE_BITS  (NOTE_BITS),
    .AGE_BITS   (AGE_BITS)
  ) u_picker (
    .gate       (gate),
    .voice_idle (voice_idle),
    .ages       (ages),
    .notes      (voice_note),
    .ev_note    (ev_note_r),
    .target     (pick),
    .needs_gap  (pick_gap)
  );

  // Ages after an assignment: the assigned voice becomes youngest and all
  // others grow older, saturating. Only committed on note-on assignment.
  always_comb begin
    ages_next  = ages;
    assign_idx = (state == SEARCH) ? pick : target_r;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (IDX_W'(i) == assign_idx) begin
        ages_next[i*AGE_BITS +: AGE_BITS] = '0;
      end else if (ages[i*AGE_BITS +: AGE_BITS] != AGE_MAX) begin
        ages_next[i*AGE_BITS +: AGE_BITS] = ages[i*AGE_BITS +: AGE_BITS] + 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ev_valid) state_next = SEARCH;
      SEARCH:  state_next = (ev_on_r && pick_gap) ? GAP : IDLE;
      GAP:     if (gap_cnt == '0) state_next = ASSIGN;
      ASSIGN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath. The re-gate of a gapped voice is registered on the last GAP
  // cycle so the gate is already high while the FSM sits in ASSIGN; that
  // keeps the gate-low window at exactly RETRIG_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate       <= '0;
      voice_note <= '0;
      ages       <= '0;
      ev_on_r    <= 1'b0;
      ev_note_r  <= '0;
      target_r   <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_valid) begin
            ev_on_r   <= ev_on;
            ev_note_r <= ev_note;
          end
        end
        SEARCH: begin
          if (!ev_on_r) begin
            // Note-off releases every matching gated voice; the note is
            // kept so the release tail plays at the same pitch.
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (gate[i] && voice_note[i*NOTE_BITS +: NOTE_BITS] == ev_note_r)
                gate[i] <= 1'b0;
            end
          end else begin
            target_r <= pick;
            voice_note[pick*NOTE_BITS +: NOTE_BITS] <= ev_note_r;
            if (pick_gap) begin
              gate[pick] <= 1'b0;
              gap_cnt    <= GAP_W'(RETRIG_CYCLES - 1);
            end else begin
              gate[pick] <= 1'b1;
              ages       <= ages_next;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            gate[target_r] <= 1'b1;
            ages           <= ages_next;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator (4 voices, 7-bit
// notes, 4-bit ages, 2-cycle retrigger gap). Inputs change 1 ns after
// the rising edge and outputs are sampled at that same point.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_on;
  logic [6:0]  ev_note;
  logic [3:0]  voice_idle;
  logic [3:0]  gate;
  logic [27:0] voice_note;
  logic        busy;

  int errors = 0;
  int checks = 0;

  voice_allocator #(
    .NUM_VOICES    (4),
    .NOTE_BITS     (7),
    .AGE_BITS      (4),
    .RETRIG_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_on      (ev_on),
    .ev_note    (ev_note),
    .voice_idle (voice_idle),
    .gate       (gate),
    .voice_note (voice_note),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one event for exactly one cycle (handshake = cycle 0).
  // Returns in cycle 1.
  task automatic send(input logic on, input logic [6:0] note);
    checks++;
    if (ev_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL send_ready: ev_ready=%b expected 1", ev_ready);
    end
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = note;
    tick();
    ev_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; voice_idle = 4'hF;
    tick(); tick();
    checks++; if (gate !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gate: got %b expected 0000", gate); end
    checks++; if (voice_note !== 28'd0) begin errors++; $display("[TB] FAIL reset_notes: got %h expected 0", voice_note); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ev_ready); end
    rst = 1'b0;
    #1;
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready: got %b expected 1", ev_ready); end
  endtask

  task automatic test_free_assign();
    send(1'b1, 7'd60);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL free_c1_busy: got %b expected 1", busy); end
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("[TB] FAIL free_c1_ready: got %b expected 0", ev_ready); end
    tick();
    checks++; if (gate !== 4'b0001) begin errors++; $display("[TB] FAIL free_c2_gate: got %b expected 0001", gate); end
    checks++; if (voice_note[6:0] !== 7'd60) begin errors++; $display("[TB] FAIL free_c2_note0: got %0d expected 60", voice_note[6:0]); end
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("[TB] FAIL free_c2_ready: got %b expected 1", ev_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL free_c2_busy: got %b expected 0", busy); end
  endtask

  // Fill voices 1..3, then release 62. Ages become v0=3 v1=2 v2=1 v3=0.
  task automatic test_fill_and_release();
    logic [6:0] fill [3];
    fill = '{7'd62, 7'd64, 7'd67};
    for (int i = 0; i < 3; i++) begin
      send(1'b1, fill[i]);
      tick();
    end
    checks++; if (gate !== 4'b1111) begin errors++; $display("[TB] FAIL fill_gate: got %b expected 1111", gate); end
    checks++; if (voice_note !== {7'd67, 7'd64, 7'd62, 7'd60}) begin errors++; $display("[TB] FAIL fill_notes: got %h expected %h", voice_note, {7'd67, 7'd64, 7'd62, 7'd60}); end
    voice_idle = 4'b0000;
    send(1'b0, 7'd62);
    tick();
    checks++; if (gate !== 4'b1101) begin errors++; $display("[TB] FAIL off_gate: got %b expected 1101", gate); end
    checks++; if (voice_note[13:7] !== 7'd62) begin errors++; $display("[TB] FAIL off_note1_kept: got %0d expected 62", voice_note[13:7]); end
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("[TB] FAIL off_ready: got %b expected 1", ev_ready); end
  endtask

  // Voice 1 is releasing (not idle); it is chosen without a gap.
  // Ages afterwards: v0=4 v1=0 v2=2 v3=1.
  task automatic test_releasing_pick();
    send(1'b1, 7'd65);
    tick();
    checks++; if (gate !== 4'b1111) begin errors++; $display("[TB] FAIL rel_gate: got %b expected 1111", gate); end
    checks++; if (voice_note[13:7] !== 7'd65) begin errors++; $display("[TB] FAIL rel_note1: got %0d expected 65", voice_note[13:7]); end
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("[TB] FAIL rel_ready: got %b expected 1", ev_ready); end
  endtask

  // Steal oldest (v0, age 4) for 72, then oldest again (v2, age 3) for 74.
  task automatic test_steal();
    send(1'b1, 7'd72);
    tick();
    checks++; if (gate !== 4'b1110) begin errors++; $display("[TB] FAIL steal_c2_gate: got %b expected 1110", gate); end
    checks++; if (voice_note[6:0] !== 7'd72) begin errors++; $display("[TB] FAIL steal_c2_note0: got %0d expected 72", voice_note[6:0]); end
    tick();
    checks++; if (gate !== 4'b1110) begin errors++; $display("[TB] FAIL steal_c3_gate: got %b expected 1110", gate); end
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("[TB] FAIL steal_c3_ready: got %b expected 0", ev_ready); end
    tick();
    checks++; if (gate !== 4'b1111) begin errors++; $display("[TB] FAIL steal_c4_gate: got %b expected 1111", gate); end
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("[TB] FAIL steal_c4_ready: got %b expected 0", ev_ready); end
    tick();
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("[TB] FAIL steal_c5_ready: got %b expected 1", ev_ready); end
    send(1'b1, 7'd74);
    tick(); tick();
    checks++; if (gate !== 4'b1011) begin errors++; $display("[TB] FAIL steal2_c3_gate: got %b expected 1011", gate); end
    tick(); tick();
    checks++; if (gate !== 4'b1111) begin errors++; $display("[TB] FAIL steal2_c5_gate: got %b expected 1111", gate); end
    checks++; if (voice_note[20:14] !== 7'd74) begin errors++; $display("[TB] FAIL steal2_note2: got %0d expected 74", voice_note[20:14]); end
  endtask

  // Note 72 already gated on v0: same voice retriggers, others untouched.
  task automatic test_retrigger();
    send(1'b1, 7'd72);
    tick();
    checks++; if (gate !== 4'b1110) begin errors++; $display("[TB] FAIL retrig_c2_gate: got %b expected 1110", gate); end
    tick();
    checks++; if (gate !== 4'b1110) begin errors++; $display("[TB] FAIL retrig_c3_gate: got %b expected 1110", gate); end
    tick();
    checks++; if (gate !== 4'b1111) begin errors++; $display("[TB] FAIL retrig_c4_gate: got %b expected 1111", gate); end
    checks++; if (voice_note !== {7'd67, 7'd74, 7'd65, 7'd72}) begin errors++; $display("[TB] FAIL retrig_notes: got %h expected %h", voice_note, {7'd67, 7'd74, 7'd65, 7'd72}); end
    tick();
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("[TB] FAIL retrig_c5_ready: got %b expected 1", ev_ready); end
  endtask

  task automatic test_noteoff_nomatch();
    send(1'b0, 7'd50);
    tick();
    checks++; if (gate !== 4'b1111) begin errors++; $display("[TB] FAIL nomatch_gate: got %b expected 1111", gate); end
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("[TB] FAIL nomatch_ready: got %b expected 1", ev_ready); end
  endtask

  task automatic test_reset_in_gap();
    send(1'b1, 7'd67);
    tick();
    checks++; if (gate !== 4'b0111 || busy !== 1'b1) begin errors++; $display("[TB] FAIL gap_entry: gate=%b busy=%b expected 0111/1", gate, busy); end
    rst = 1'b1; ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd10;
    #1;
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %b expected 0", ev_ready); end
    tick();
    checks++; if (gate !== 4'b0000) begin errors++; $display("[TB] FAIL rst_gap_gate: got %b expected 0000", gate); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_gap_busy: got %b expected 0", busy); end
    checks++; if (voice_note !== 28'd0) begin errors++; $display("[TB] FAIL rst_gap_notes: got %h expected 0", voice_note); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_hold_busy: got %b expected 0", busy); end
    ev_valid = 1'b0; rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || gate !== 4'b0000) begin errors++; $display("[TB] FAIL rst_after: busy=%b gate=%b expected 0/0000", busy, gate); end
  endtask

  // With all gates low, the lowest-index idle voice wins.
  task automatic test_idle_priority();
    voice_idle = 4'b1100;
    send(1'b1, 7'd40);
    tick();
    checks++; if (gate !== 4'b0100) begin errors++; $display("[TB] FAIL idle_gate: got %b expected 0100", gate); end
    checks++; if (voice_note[20:14] !== 7'd40) begin errors++; $display("[TB] FAIL idle_note2: got %0d expected 40", voice_note[20:14]); end
  endtask

  initial begin
    test_reset();
    test_free_assign();
    test_fill_and_release();
    test_releasing_pick();
    test_steal();
    test_retrigger();
    test_noteoff_nomatch();
    test_reset_in_gap();
    test_idle_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
